// File: rtl/icache_dm_pkg.sv
// Shared instruction-cache types: address split, frame layout and FSM state.
// Imported by the frame array and the cache controller.
package icache_dm_pkg;

    typedef logic [31:0] word_t;

    localparam int IIDX_W  = 4;
    localparam int ITAG_W  = 26;
    localparam int IBYT_W  = 2;
    localparam int IFRAMES = 2 ** IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    typedef enum logic {
        ICACHE_IDLE,
        ICACHE_FILL
    } icache_state_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: combinational read, synchronous write,
// synchronous invalidate-all (reset or flush).
module icache_frame_array
    import icache_dm_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_flush,
    input  logic [IIDX_W-1:0]   i_ridx,
    output icache_frame_t       o_rframe,
    input  logic                i_we,
    input  logic [IIDX_W-1:0]   i_widx,
    input  icache_frame_t       i_wframe
);

    icache_frame_t r_frames [IFRAMES];

    assign o_rframe = r_frames[i_ridx];

    // Invalidation is applied after the write so a flush wins over a fill.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_frames[i_widx] <= i_wframe;
        end
        if (RST || i_flush) begin
            for (int i = 0; i < IFRAMES; i++) begin
                r_frames[i].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped single-word instruction cache with one-word fill,
// fill-data forwarding and hit/miss performance counters.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dp_iren,
    input  logic [31:0]      dp_imemaddr,
    output logic             dp_ihit,
    output logic [31:0]      dp_imemload,
    input  logic             flush,
    output logic             mem_iren,
    output logic [31:0]      mem_iaddr,
    input  logic             mem_iwait,
    input  logic [31:0]      mem_iload,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    icache_state_t    r_state;
    word_t            r_maddr;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    icachef_t         w_addr;
    icachef_t         w_maddr;
    icache_frame_t    w_rframe;
    icache_frame_t    w_wframe;
    logic             w_hit;
    logic             w_done;
    logic             w_fwd;
    logic             w_we;
    logic             w_unused_boff;

    assign w_addr        = icachef_t'(dp_imemaddr);
    assign w_maddr       = icachef_t'(r_maddr);
    assign w_unused_boff = ^{w_addr.bytoff, w_maddr.bytoff};

    icache_frame_array u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .i_flush  (flush),
        .i_ridx   (w_addr.idx),
        .o_rframe (w_rframe),
        .i_we     (w_we),
        .i_widx   (w_maddr.idx),
        .i_wframe (w_wframe)
    );

    assign w_hit = (r_state == ICACHE_IDLE) & dp_iren & w_rframe.valid
                 & (w_rframe.tag == w_addr.tag);

    assign w_done = (r_state == ICACHE_FILL) & ~mem_iwait;
    assign w_we   = w_done & ~RST;

    // Forward only when fetch still wants the word being filled.
    assign w_fwd = w_done & dp_iren
                 & (dp_imemaddr[31:2] == r_maddr[31:2]);

    assign w_wframe.valid = 1'b1;
    assign w_wframe.tag   = w_maddr.tag;
    assign w_wframe.data  = mem_iload;

    assign dp_ihit     = w_hit | w_fwd;
    assign dp_imemload = w_hit ? w_rframe.data
                       : w_fwd ? mem_iload
                       : 32'h0;

    assign mem_iren  = (r_state == ICACHE_FILL);
    assign mem_iaddr = r_maddr;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ICACHE_IDLE;
            r_maddr    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            unique case (r_state)
                ICACHE_IDLE: begin
                    if (w_hit) begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else if (dp_iren) begin
                        r_maddr    <= {dp_imemaddr[31:2], 2'b00};
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_state    <= ICACHE_FILL;
                    end
                end
                ICACHE_FILL: begin
                    if (!mem_iwait) begin
                        r_state <= ICACHE_IDLE;
                    end
                end
                default: r_state <= ICACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fills, hits, conflicts, redirect,
// flush-on-completion, byte-offset aliasing and mid-fill reset.
module tb_icache_dm;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dp_iren;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        flush;
    logic        mem_iren;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_pass = 0;
    int n_total = 0;

    icache_dm #(.CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .dp_iren     (dp_iren),
        .dp_imemaddr (dp_imemaddr),
        .dp_ihit     (dp_ihit),
        .dp_imemload (dp_imemload),
        .flush       (flush),
        .mem_iren    (mem_iren),
        .mem_iaddr   (mem_iaddr),
        .mem_iwait   (mem_iwait),
        .mem_iload   (mem_iload),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, wait nwait busy cycles, then complete with data.
    task automatic fill(input logic [31:0] addr, input logic [31:0] data,
                        input int nwait, input bit fwd);
        dp_iren = 1'b1;
        dp_imemaddr = addr;
        mem_iwait = 1'b1;
        #2;
        chk("miss_ihit", {31'b0, dp_ihit}, 32'd0);
        chk("miss_iren", {31'b0, mem_iren}, 32'd0);
        cyc();
        for (int i = 0; i < nwait; i++) begin
            #2;
            chk("wait_iren", {31'b0, mem_iren}, 32'd1);
            chk("wait_iaddr", mem_iaddr, {addr[31:2], 2'b00});
            chk("wait_ihit", {31'b0, dp_ihit}, 32'd0);
            cyc();
        end
        mem_iwait = 1'b0;
        mem_iload = data;
        #2;
        chk("done_iren", {31'b0, mem_iren}, 32'd1);
        chk("done_iaddr", mem_iaddr, {addr[31:2], 2'b00});
        chk("fwd_ihit", {31'b0, dp_ihit}, {31'b0, fwd});
        chk("fwd_load", dp_imemload, fwd ? data : 32'h0);
        cyc();
        mem_iwait = 1'b1;
        mem_iload = 32'hDEAD_BEEF;
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data);
        dp_iren = 1'b1;
        dp_imemaddr = addr;
        #2;
        chk("hit_ihit", {31'b0, dp_ihit}, 32'd1);
        chk("hit_load", dp_imemload, data);
        chk("hit_iren", {31'b0, mem_iren}, 32'd0);
        cyc();
    endtask

    initial begin
        RST = 1'b1;
        dp_iren = 1'b0;
        dp_imemaddr = 32'h0;
        flush = 1'b0;
        mem_iwait = 1'b1;
        mem_iload = 32'h0;
        cyc();
        cyc();
        RST = 1'b0;
        #2;
        chk("rst_ihit", {31'b0, dp_ihit}, 32'd0);
        chk("rst_load", dp_imemload, 32'h0);
        chk("rst_iren", {31'b0, mem_iren}, 32'd0);
        chk("rst_iaddr", mem_iaddr, 32'h0);
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        cyc();

        // 1: cold miss with 3 wait cycles, forward, then same-cycle hit
        fill(32'h0000_0040, 32'h2001_0005, 3, 1'b1);
        chk("t1_miss", miss_cnt, 32'd1);
        fetch_hit(32'h0000_0040, 32'h2001_0005);
        chk("t1_hits", hit_cnt, 32'd1);

        // 2: conflict on idx 0
        fill(32'h0000_0440, 32'h1111_0440, 1, 1'b1);
        fetch_hit(32'h0000_0440, 32'h1111_0440);
        fill(32'h0000_0040, 32'h2001_0005, 0, 1'b1);
        chk("t2_miss", miss_cnt, 32'd3);
        chk("t2_hits", hit_cnt, 32'd2);

        // 3: redirect during fill of 0x80
        dp_iren = 1'b1;
        dp_imemaddr = 32'h0000_0080;
        #2;
        chk("t3_miss", {31'b0, dp_ihit}, 32'd0);
        cyc();
        dp_imemaddr = 32'h0000_0100;
        #2;
        chk("t3_iaddr", mem_iaddr, 32'h0000_0080);
        chk("t3_wihit", {31'b0, dp_ihit}, 32'd0);
        cyc();
        mem_iwait = 1'b0;
        mem_iload = 32'hAAAA_0080;
        #2;
        chk("t3_nofwd", {31'b0, dp_ihit}, 32'd0);
        chk("t3_noload", dp_imemload, 32'h0);
        cyc();
        mem_iwait = 1'b1;
        #2;
        chk("t3_idle", {31'b0, mem_iren}, 32'd0);
        chk("t3_newmiss", {31'b0, dp_ihit}, 32'd0);
        fetch_hit(32'h0000_0080, 32'hAAAA_0080);
        fill(32'h0000_0100, 32'hBBBB_0100, 0, 1'b1);
        chk("t3_miss_cnt", miss_cnt, 32'd5);
        chk("t3_hits", hit_cnt, 32'd3);

        // 4: flush coincident with fill completion of 0xC0
        dp_imemaddr = 32'h0000_00C0;
        cyc();
        mem_iwait = 1'b0;
        mem_iload = 32'hCCCC_00C0;
        flush = 1'b1;
        #2;
        chk("t4_fwd", {31'b0, dp_ihit}, 32'd1);
        cyc();
        flush = 1'b0;
        mem_iwait = 1'b1;
        #2;
        chk("t4_idle", {31'b0, mem_iren}, 32'd0);
        fill(32'h0000_00C0, 32'hCCCC_00C0, 0, 1'b1);
        chk("t4_miss", miss_cnt, 32'd7);

        // 5: byte offset ignored
        fill(32'h0000_0024, 32'h2424_2424, 2, 1'b1);
        fetch_hit(32'h0000_0027, 32'h2424_2424);
        chk("t5_hits", hit_cnt, 32'd4);
        chk("t5_miss", miss_cnt, 32'd8);

        // 6: reset while fill is stalled
        dp_imemaddr = 32'h0000_0300;
        cyc();
        #2;
        chk("t6_iren", {31'b0, mem_iren}, 32'd1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        #2;
        chk("t6_iren0", {31'b0, mem_iren}, 32'd0);
        chk("t6_hits0", hit_cnt, 32'd0);
        chk("t6_miss0", miss_cnt, 32'd0);
        chk("t6_remiss", {31'b0, dp_ihit}, 32'd0);
        cyc();
        chk("t6_miss1", miss_cnt, 32'd1);
        chk("t6_iaddr", mem_iaddr, 32'h0000_0300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
